// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment display arbiter.
// Blank pattern, FSM state encoding, default requester count, digit slicing.
package seg_pkg;

  localparam int SEG_N_REQ = 3;
  localparam int SEG_DIG_W = 8;
  localparam int SEG_N_DIG = 8;
  localparam int SEG_PAT_W = SEG_DIG_W * SEG_N_DIG;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_PAT_W-1:0] SEG_PAT_BLANK = {SEG_N_DIG{SEG_BLANK}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } seg_state_e;

  // digit k occupies bits [63-8k : 56-8k]; digit 0 is the MSB byte
  function automatic int seg_dig_hi(input int k);
    return SEG_PAT_W - 1 - SEG_DIG_W * k;
  endfunction

  function automatic logic [SEG_DIG_W-1:0] seg_digit(
    input logic [SEG_PAT_W-1:0] p,
    input int                   k
  );
    return p[seg_dig_hi(k) -: SEG_DIG_W];
  endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// seg_blink_timer: free-running 0..BLINK_DIV-1 counter and blink phase flop.
// Ports: clk, rst (async active-low), phase_q (current phase), wrap (counter at top).
module seg_blink_timer #(
  parameter logic [23:0] BLINK_DIV = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic phase_q,
  output logic wrap
);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic        phase_d;

  always_comb begin
    wrap    = (cnt_q == BLINK_DIV - 24'd1);
    cnt_d   = wrap ? 24'd0 : cnt_q + 24'd1;
    phase_d = phase_q ^ wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 24'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: priority arbiter with minimum hold time sharing the
// 8-digit display. Optional blink feature under macro SEG_BLINK_EN.
// Ports: clk, rst (async active-low), req/gnt one-hot handshake, pats
// (64 bits per requester), blink (SEG_BLINK_EN only), busy, o0..o7 digits.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int          N_REQ     = SEG_N_REQ,
  parameter logic [15:0] HOLD_CYC  = 16'd5000,
  parameter logic [23:0] BLINK_DIV = 24'd5_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*64-1:0]    pats,
`ifdef SEG_BLINK_EN
  input  logic [N_REQ-1:0]       blink,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [7:0]             o0,
  output logic [7:0]             o1,
  output logic [7:0]             o2,
  output logic [7:0]             o3,
  output logic [7:0]             o4,
  output logic [7:0]             o5,
  output logic [7:0]             o6,
  output logic [7:0]             o7
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] HOLD_MAX = HOLD_CYC - 16'd1;

  if (HOLD_CYC == 16'd0) begin : g_bad_hold
    $error("HOLD_CYC must be at least 1");
  end
  if (BLINK_DIV == 24'd0) begin : g_bad_div
    $error("BLINK_DIV must be at least 1");
  end

  function automatic logic [IDX_W-1:0] lowest(
    input logic [N_REQ-1:0] v
  );
    lowest = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  seg_state_e           state_q, state_d;
  logic [IDX_W-1:0]     own_q, own_d;
  logic [15:0]          hold_q, hold_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [SEG_PAT_W-1:0] pat_q, pat_d;
  logic [N_REQ-1:0]     below;
  logic [N_REQ-1:0]     hi_req;
  logic                 blank_blink;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    hold_d  = hold_q;
    for (int i = 0; i < N_REQ; i++) begin
      below[i] = (i < int'(own_q));
    end
    hi_req = req & below;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWN;
          own_d   = lowest(req);
          hold_d  = 16'd0;
        end
      end
      ST_OWN: begin
        if (!req[own_q]) begin
          // release always passes through one blank IDLE cycle
          state_d = ST_IDLE;
          hold_d  = 16'd0;
        end else if ((|hi_req) && (hold_q == HOLD_MAX)) begin
          own_d  = lowest(hi_req);
          hold_d = 16'd0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEG_BLINK_EN
  logic phase_q;
  logic phase_wrap;

  seg_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .phase_q (phase_q),
    .wrap    (phase_wrap)
  );

  // use the phase that will hold after this edge so blanking
  // lines up with the registered outputs
  assign blank_blink = blink[own_d] & (phase_q ^ phase_wrap);
`else
  assign blank_blink = 1'b0;
`endif

  always_comb begin
    gnt_d = '0;
    pat_d = SEG_PAT_BLANK;
    if (state_d == ST_OWN) begin
      gnt_d[own_d] = 1'b1;
      if (!blank_blink) begin
        pat_d = pats[int'(own_d)*SEG_PAT_W +: SEG_PAT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      hold_q  <= 16'd0;
      gnt_q   <= '0;
      pat_q   <= SEG_PAT_BLANK;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      pat_q   <= pat_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;
  assign o0   = seg_digit(pat_q, 0);
  assign o1   = seg_digit(pat_q, 1);
  assign o2   = seg_digit(pat_q, 2);
  assign o3   = seg_digit(pat_q, 3);
  assign o4   = seg_digit(pat_q, 4);
  assign o5   = seg_digit(pat_q, 5);
  assign o6   = seg_digit(pat_q, 6);
  assign o7   = seg_digit(pat_q, 7);

endmodule
